// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the FP add/sub datapath: GRS width, alignment FSM
// state encoding and the saturated-op counter width.
package fp_addsub_pkg;

  // Guard, round and sticky bits appended below the mantissa.
  localparam int unsigned GRS_BITS = 3;

  // Width of the optional saturated-operation counter.
  localparam int unsigned SAT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;

endpackage

// File: rtl/sticky_right_shift.sv
// Combinational logical right shift by at most MaxShift bits. Every bit shifted
// out is OR-ed into bit 0 so the sticky information survives the shift.
module sticky_right_shift #(
  parameter int unsigned Width    = 27,
  parameter int unsigned MaxShift = 4,
  localparam int unsigned AmtW    = $clog2(MaxShift + 1)
) (
  input  logic [Width-1:0] value,
  input  logic [AmtW-1:0]  amount,
  output logic [Width-1:0] result
);

  logic [Width-1:0] lost_mask;
  logic             dropped;

  // Shift, then fold the dropped low bits into the sticky position.
  always_comb begin
    lost_mask = ~({Width{1'b1}} << amount);
    dropped   = |(value & lost_mask);
    result    = (value >> amount) | {{(Width - 1){1'b0}}, dropped};
  end

endmodule

// File: rtl/mantissa_align_shifter.sv
// Alignment stage of the FP add/sub datapath. Picks the mantissa with the
// smaller exponent and right-shifts it by the exponent difference, ShiftStep
// bits per cycle, keeping guard/round/sticky bits. Results leave over a
// valid/ready handshake.
// Optional feature: define MANTISSA_ALIGN_SAT_COUNT_EN to add the SatCount
// output counting accepted operations whose shift saturated.
module mantissa_align_shifter
  import fp_addsub_pkg::*;
#(
  parameter int unsigned ExponentSize = 8,
  parameter int unsigned MantissaSize = 24,
  parameter int unsigned ShiftStep    = 4,
  localparam int unsigned W           = MantissaSize + GRS_BITS
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [MantissaSize-1:0] Mantissa1,
  input  logic [MantissaSize-1:0] Mantissa2,
  input  logic [ExponentSize-1:0] Difference,
  input  logic                    Sign,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [W-1:0]            AlignedLarge,
  output logic [W-1:0]            AlignedSmall,
  output logic                    Swapped,
  output logic                    Saturated
`ifdef MANTISSA_ALIGN_SAT_COUNT_EN
  ,
  output logic [SAT_CNT_WIDTH-1:0] SatCount
`endif
);

  localparam int unsigned AmtW = $clog2(ShiftStep + 1);

  align_state_e      state_q;
  logic [ExponentSize-1:0] rem_q;
  logic [W-1:0]      large_q;
  logic [W-1:0]      small_q;
  logic              swapped_q;
  logic              sat_q;

  logic [MantissaSize-1:0] sel_large;
  logic [MantissaSize-1:0] sel_small;
  logic                    sat_hit;
  logic                    accept;
  logic [AmtW-1:0]         step_amt;
  logic [W-1:0]            shifted_small;

  // Operand selection and per-cycle shift distance.
  always_comb begin
    sel_large = Sign ? Mantissa2 : Mantissa1;
    sel_small = Sign ? Mantissa1 : Mantissa2;
    sat_hit   = 32'(Difference) >= W;
    accept    = InValid && (state_q == IDLE);
    if (32'(rem_q) < ShiftStep) begin
      step_amt = AmtW'(rem_q);
    end else begin
      step_amt = AmtW'(ShiftStep);
    end
  end

  sticky_right_shift #(
    .Width   (W),
    .MaxShift(ShiftStep)
  ) u_shift (
    .value (small_q),
    .amount(step_amt),
    .result(shifted_small)
  );

  // Alignment FSM: capture operands, shift iteratively, hold until taken.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      large_q   <= '0;
      small_q   <= '0;
      swapped_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (InValid) begin
            large_q   <= {sel_large, {GRS_BITS{1'b0}}};
            swapped_q <= Sign;
            rem_q     <= Difference;
            if (sat_hit) begin
              // Everything falls below the sticky bit; only "nonzero" remains.
              small_q <= {{(W - 1){1'b0}}, |sel_small};
              sat_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              small_q <= {sel_small, {GRS_BITS{1'b0}}};
              sat_q   <= 1'b0;
              state_q <= (Difference == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          small_q <= shifted_small;
          rem_q   <= rem_q - ExponentSize'(step_amt);
          if (rem_q == ExponentSize'(step_amt)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InReady      = (state_q == IDLE);
  assign OutValid     = (state_q == DONE);
  assign AlignedLarge = large_q;
  assign AlignedSmall = small_q;
  assign Swapped      = swapped_q;
  assign Saturated    = sat_q;

`ifdef MANTISSA_ALIGN_SAT_COUNT_EN
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;

  // Count accepted saturating ops, sticking at the maximum value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sat_cnt_q <= '0;
    end else if (accept && sat_hit && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign SatCount = sat_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mantissa_align_shifter.sv
// Self-checking bench for mantissa_align_shifter: directed cases with literal
// expectations plus a randomized run checked every cycle against a
// transaction-level model.
module tb_mantissa_align_shifter;

  localparam int ES   = 8;
  localparam int MS   = 24;
  localparam int STEP = 4;
  localparam int W    = MS + 3;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          InValid;
  logic          InReady;
  logic [MS-1:0] Mantissa1;
  logic [MS-1:0] Mantissa2;
  logic [ES-1:0] Difference;
  logic          Sign;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  AlignedLarge;
  logic [W-1:0]  AlignedSmall;
  logic          Swapped;
  logic          Saturated;
`ifdef MANTISSA_ALIGN_SAT_COUNT_EN
  logic [15:0]   SatCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mantissa_align_shifter #(
    .ExponentSize(ES),
    .MantissaSize(MS),
    .ShiftStep   (STEP)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .Mantissa1   (Mantissa1),
    .Mantissa2   (Mantissa2),
    .Difference  (Difference),
    .Sign        (Sign),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .AlignedLarge(AlignedLarge),
    .AlignedSmall(AlignedSmall),
    .Swapped     (Swapped),
    .Saturated   (Saturated)
`ifdef MANTISSA_ALIGN_SAT_COUNT_EN
    ,
    .SatCount    (SatCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Aligned small mantissa as one big shift: bits below position 0 collapse into sticky.
  function automatic logic [63:0] model_small(input logic [MS-1:0] m, input int d);
    logic [63:0] full;
    logic [63:0] lost;
    full = {37'd0, m, 3'b000};
    if (d == 0) return full;
    if (d >= W) return {63'd0, |m};
    lost = full & ((64'd1 << d) - 64'd1);
    return (full >> d) | {63'd0, lost != 64'd0};
  endfunction

  // Transaction-level model: 0 = can accept, 1 = busy, 2 = result offered.
  int          m_phase;
  int          m_cnt;
  logic [63:0] m_large;
  logic [63:0] m_small;
  logic        m_swapped;
  logic        m_sat;
  logic        m_clean;
  int          m_satcnt;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_phase <= 0; m_cnt <= 0; m_large <= 0; m_small <= 0;
      m_swapped <= 0; m_sat <= 0; m_clean <= 1; m_satcnt <= 0;
    end else begin
      if (m_phase == 0 && InValid) begin
        int d;
        int lat;
        d = int'(Difference);
        lat = (d == 0 || d >= W) ? 0 : (d + STEP - 1) / STEP;
        m_large   <= {37'd0, (Sign ? Mantissa2 : Mantissa1), 3'b000};
        m_small   <= model_small(Sign ? Mantissa1 : Mantissa2, d);
        m_swapped <= Sign;
        m_sat     <= (d >= W);
        m_clean   <= 0;
        if (d >= W && m_satcnt < 65535) m_satcnt <= m_satcnt + 1;
        m_cnt     <= lat;
        m_phase   <= (lat == 0) ? 2 : 1;
      end else if (m_phase == 1) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_phase <= 2;
      end else if (m_phase == 2 && OutReady) begin
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    check("in_ready", {63'd0, InReady}, {63'd0, m_phase == 0});
    check("out_valid", {63'd0, OutValid}, {63'd0, m_phase == 2});
    if (m_phase == 2) begin
      check("aligned_large", {37'd0, AlignedLarge}, m_large);
      check("aligned_small", {37'd0, AlignedSmall}, m_small);
      check("swapped", {63'd0, Swapped}, {63'd0, m_swapped});
      check("saturated", {63'd0, Saturated}, {63'd0, m_sat});
    end
    if (m_clean) begin
      check("reset_outputs", {8'd0, AlignedLarge, AlignedSmall, Swapped, Saturated}, 64'd0);
    end
`ifdef MANTISSA_ALIGN_SAT_COUNT_EN
    check("sat_count", {48'd0, SatCount}, 64'(m_satcnt));
`endif
  end

  // Directed op with literal expectations; starts and ends just after a rising edge, DUT idle.
  task automatic run_op(input string name, input logic [MS-1:0] m1, input logic [MS-1:0] m2,
                        input int d, input logic sgn, input int hold,
                        input logic [W-1:0] exp_large, input logic [W-1:0] exp_small,
                        input int exp_lat);
    int n;
    Mantissa1 = m1; Mantissa2 = m2; Difference = ES'(d); Sign = sgn;
    OutReady = (hold == 0);
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    n = 0;
    @(negedge Clk);
    while (!OutValid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_large"}, {37'd0, AlignedLarge}, {37'd0, exp_large});
    check({name, "_small"}, {37'd0, AlignedSmall}, {37'd0, exp_small});
    if (hold > 0) begin
      repeat (hold) @(posedge Clk);
      #1 OutReady = 1'b1;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    Mantissa1 = '0; Mantissa2 = '0; Difference = '0; Sign = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;

    run_op("t1", 24'hC00000, 24'h800000, 1, 1'b0, 0, 27'h6000000, 27'h2000000, 1);
    check("t1_swapped", {63'd0, Swapped}, 64'd0);
    run_op("t2", 24'h800001, 24'hABCDEF, 30, 1'b1, 0, 27'h55E6F78, 27'h0000001, 0);
    check("t2_saturated", {63'd0, Saturated}, 64'd1);
    check("t2_swapped", {63'd0, Swapped}, 64'd1);
`ifdef MANTISSA_ALIGN_SAT_COUNT_EN
    check("t2_sat_count", {48'd0, SatCount}, 64'd1);
`endif
    run_op("t3", 24'hFFFFFF, 24'h800000, 26, 1'b0, 0, 27'h7FFFFF8, 27'h0000001, 7);
    check("t3_saturated", {63'd0, Saturated}, 64'd0);
    run_op("t4", 24'h900000, 24'h800007, 4, 1'b0, 0, 27'h4800000, 27'h0400003, 1);
    run_op("t5", 24'h123456, 24'h654321, 0, 1'b1, 5, 27'h32A1908, 27'h091A2B0, 0);

    // Reset while shifting discards the operation.
    Mantissa1 = 24'hFFFFFF; Mantissa2 = 24'h800000; Difference = 8'd20; Sign = 1'b0;
    InValid = 1'b1;
    @(posedge Clk); #1 InValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, OutValid}, 64'd0);
    check("rst_in_ready", {63'd0, InReady}, 64'd1);
    check("rst_small", {37'd0, AlignedSmall}, 64'd0);
    check("rst_large", {37'd0, AlignedLarge}, 64'd0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    repeat (8) @(posedge Clk);
    #1;

    // Randomized traffic with random backpressure; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      InValid    = ($urandom % 2) == 0;
      Mantissa1  = {1'b1, 23'($urandom)};
      Mantissa2  = ($urandom % 8 == 0) ? MS'($urandom) : {1'b1, 23'($urandom)};
      Difference = ($urandom % 5 == 0) ? ES'($urandom) : ES'($urandom_range(0, 30));
      Sign       = ($urandom % 2) == 0;
      OutReady   = ($urandom % 4) != 0;
      @(posedge Clk); #1;
    end
    InValid = 1'b0; OutReady = 1'b1;
    repeat (12) @(posedge Clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
